semaforo_peatonal: RTL and testbench
====================================

SEMAFORO_PEATONAL -- requirements
Module: semaforo_peatonal

Interface
REQ-001 Parameter T_DEBOUNCE, 4: cycles pulsador must stay stable before the change is accepted (1..255).
REQ-002 Parameter T_WALK, 10: cycles of steady pedestrian green (1..255).
REQ-003 Parameter T_CLEAR, 6: cycles of flashing pedestrian green (1..255).
REQ-004 Parameter T_FLASH, 2: half-period of flashing, in cycles (1..255).
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pulsador  in  1  raw pedestrian button, asynchronous, active-high.
REQ-008 rojo_in, amarillo_in, verde_in  in  1 each  vehicle lamp states from the vehicle controller, synchronous to clk.
REQ-009 solicitud  out  1  registered level; crossing requested, held until served.
REQ-010 espera  out  1  registered "wait" lamp; equals solicitud.
REQ-011 peaton_verde  out  1  registered pedestrian green lamp.
REQ-012 peaton_rojo  out  1  registered pedestrian red lamp.
REQ-013 falla  out  1  registered sticky fault flag.
REQ-014 sonido  out  1  registered acoustic crossing signal.

Function
REQ-015 pulsador SHALL pass through a 2-FF synchronizer, then a stability counter; the debounced level updates only after T_DEBOUNCE consecutive cycles of equal synchronized value.
REQ-016 Only a 0->1 transition of the debounced level counts as a press; holding the button SHALL NOT generate further presses.
REQ-017 FSM states: IDLE, ESPERA, CRUCE, DESPEJE, FIN, FALLA.
REQ-018 IDLE: peaton_rojo=1. On a press, or with a pending press, go to ESPERA and set solicitud=1.
REQ-019 ESPERA: peaton_rojo=1. On the first edge where rojo_in=1, go to CRUCE. peaton_verde=1 and peaton_rojo=0 SHALL appear on the next cycle. solicitud clears on the same edge.
REQ-020 CRUCE: peaton_verde steady for T_WALK cycles, then go to DESPEJE.
REQ-021 DESPEJE: peaton_verde toggles every T_FLASH cycles, starting high, for T_CLEAR cycles, then go to FIN with peaton_verde=0.
REQ-022 FIN: peaton_rojo=1. Go to IDLE on the first cycle where rojo_in=0.
REQ-023 If rojo_in=0 while in CRUCE or DESPEJE, the next cycle SHALL force peaton_verde=0, peaton_rojo=1 and state IDLE (safety override).
REQ-024 A press in CRUCE, DESPEJE or FIN SHALL set a single pending bit. Further presses do not accumulate. The pending bit is consumed on return to IDLE.
REQ-025 A press in ESPERA SHALL be ignored.
REQ-026 Exactly one of rojo_in, amarillo_in, verde_in must be 1. Otherwise, next cycle: state FALLA, falla=1, peaton_rojo=1, peaton_verde=0, solicitud=0, sonido=0.
REQ-027 FALLA SHALL be left only by rst. Presses are ignored in FALLA.
REQ-028 peaton_verde and peaton_rojo SHALL never both be 1. They SHALL never both be 0 outside DESPEJE flash-off phases.
REQ-029 Counters SHALL be 8-bit, SHALL saturate and never wrap, and SHALL reload to 0 on every state entry.

Reset
REQ-030 While rst=1: state=IDLE, peaton_rojo=1, all other outputs 0.
REQ-031 While rst=1: debounce counter, synchronizer, debounced level, pending bit and all timers cleared.
REQ-032 rst asserted mid-crossing SHALL yield the reset outputs on the following cycle, with no residual flash or sound.

Configuration
REQ-033 Macro SEMAFORO_PEATONAL_SONIDO_EN defined: sonido toggles every T_FLASH cycles in CRUCE, every cycle in DESPEJE, and is 0 elsewhere.
REQ-034 SEMAFORO_PEATONAL_SONIDO_EN undefined: sonido tied 0 and no sound logic is synthesized. All other behaviour is identical.

Verification
REQ-035 Bounce test: pulsador 1 for 3 cycles, 0, then 1 for 10 cycles, in IDLE -> exactly one press; solicitud=1 at most 7 cycles after the stable rise.
REQ-036 Normal crossing: solicitud=1, then rojo_in=1 from cycle k -> peaton_verde=1 at k+1 for 10 cycles, flashing 1,1,0,0,1,1, then peaton_rojo=1; solicitud=0 from k+1.
REQ-037 Override: rojo_in drops to 0 at CRUCE cycle 5 -> next cycle peaton_rojo=1, peaton_verde=0, state IDLE.
REQ-038 Pending: press during DESPEJE -> after FIN and rojo_in=0, solicitud=1 within 1 cycle; a second press adds no extra crossing.
REQ-039 Fault: rojo_in=1 and verde_in=1 simultaneously -> falla=1, peaton_rojo=1 next cycle, held until rst; rst -> falla=0.
REQ-040 With SEMAFORO_PEATONAL_SONIDO_EN defined, sonido toggles every 2 cycles in CRUCE and every cycle in DESPEJE. Without it, sonido=0 throughout REQ-036.

Source files
------------

// File: rtl/semaforo_peatonal.sv
// rtl/semaforo_peatonal.sv - pedestrian crossing controller with debounced request button
// Optional acoustic signal enabled by defining SEMAFORO_PEATONAL_SONIDO_EN.
module semaforo_peatonal #(
    parameter int T_DEBOUNCE = 4,
    parameter int T_WALK     = 10,
    parameter int T_CLEAR    = 6,
    parameter int T_FLASH    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pulsador,
    input  logic rojo_in,
    input  logic amarillo_in,
    input  logic verde_in,
    output logic solicitud,
    output logic espera,
    output logic peaton_verde,
    output logic peaton_rojo,
    output logic falla,
    output logic sonido
);

    localparam logic [7:0] DEB_LAST   = 8'(T_DEBOUNCE - 1);
    localparam logic [7:0] WALK_LAST  = 8'(T_WALK - 1);
    localparam logic [7:0] CLEAR_LAST = 8'(T_CLEAR - 1);
    localparam logic [7:0] FLASH_LAST = 8'(T_FLASH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ESPERA,
        S_CRUCE,
        S_DESPEJE,
        S_FIN,
        S_FALLA
    } state_t;

    state_t     state, state_nxt;
    logic       sync1, sync2;
    logic       deb_level;
    logic [7:0] deb_cnt;
    logic       press;
    logic       lamp_ok;
    logic       pending, pending_nxt;
    logic       entering;
    logic [7:0] timer, timer_nxt;
    logic [7:0] flash_cnt, flash_cnt_nxt;
    logic       flash, flash_nxt;
    logic       walk_nxt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // deb_cnt counts consecutive cycles the synchronized button disagrees with the debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= 8'd0;
        end else begin
            sync1 <= pulsador;
            sync2 <= sync1;
            if (sync2 == deb_level) begin
                deb_cnt <= 8'd0;
            end else if (deb_cnt >= DEB_LAST) begin
                deb_level <= sync2;
                deb_cnt   <= 8'd0;
            end else begin
                deb_cnt <= sat_inc(deb_cnt);
            end
        end
    end

    assign press   = sync2 && !deb_level && (deb_cnt >= DEB_LAST);
    assign lamp_ok = ({rojo_in, amarillo_in, verde_in} == 3'b100) ||
                     ({rojo_in, amarillo_in, verde_in} == 3'b010) ||
                     ({rojo_in, amarillo_in, verde_in} == 3'b001);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            S_IDLE: begin
                if (press || pending) begin
                    state_nxt   = S_ESPERA;
                    pending_nxt = 1'b0;
                end
            end
            S_ESPERA: begin
                if (rojo_in) state_nxt = S_CRUCE;
            end
            S_CRUCE: begin
                if (press) pending_nxt = 1'b1;
                if (!rojo_in)               state_nxt = S_IDLE;
                else if (timer >= WALK_LAST) state_nxt = S_DESPEJE;
            end
            S_DESPEJE: begin
                if (press) pending_nxt = 1'b1;
                if (!rojo_in)                 state_nxt = S_IDLE;
                else if (timer >= CLEAR_LAST) state_nxt = S_FIN;
            end
            S_FIN: begin
                if (press) pending_nxt = 1'b1;
                if (!rojo_in) state_nxt = S_IDLE;
            end
            S_FALLA: begin
                state_nxt = S_FALLA;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // an inconsistent vehicle lamp set overrides every other decision
        if (!lamp_ok) begin
            state_nxt   = S_FALLA;
            pending_nxt = 1'b0;
        end
    end

    assign entering = (state_nxt != state);

    always_comb begin
        timer_nxt     = sat_inc(timer);
        flash_cnt_nxt = sat_inc(flash_cnt);
        flash_nxt     = flash;
        if (entering) begin
            timer_nxt     = 8'd0;
            flash_cnt_nxt = 8'd0;
            flash_nxt     = 1'b1;
        end else if (flash_cnt >= FLASH_LAST) begin
            flash_cnt_nxt = 8'd0;
            flash_nxt     = !flash;
        end
    end

    assign walk_nxt = (state_nxt == S_CRUCE) || (state_nxt == S_DESPEJE);

    // outputs are registered from the next-state decode so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pending      <= 1'b0;
            timer        <= 8'd0;
            flash_cnt    <= 8'd0;
            flash        <= 1'b0;
            solicitud    <= 1'b0;
            espera       <= 1'b0;
            peaton_verde <= 1'b0;
            peaton_rojo  <= 1'b1;
            falla        <= 1'b0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            timer        <= timer_nxt;
            flash_cnt    <= flash_cnt_nxt;
            flash        <= flash_nxt;
            solicitud    <= (state_nxt == S_ESPERA);
            espera       <= (state_nxt == S_ESPERA);
            peaton_verde <= (state_nxt == S_CRUCE) || ((state_nxt == S_DESPEJE) && flash_nxt);
            peaton_rojo  <= !walk_nxt;
            falla        <= (state_nxt == S_FALLA);
        end
    end

`ifdef SEMAFORO_PEATONAL_SONIDO_EN
    logic snd_phase, snd_phase_nxt;
    logic sonido_nxt;

    // walking beat follows the flash divider; clearance beat toggles every cycle
    always_comb begin
        snd_phase_nxt = entering ? 1'b1 : !snd_phase;
        sonido_nxt    = 1'b0;
        if (state_nxt == S_CRUCE)        sonido_nxt = flash_nxt;
        else if (state_nxt == S_DESPEJE) sonido_nxt = snd_phase_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snd_phase <= 1'b0;
            sonido    <= 1'b0;
        end else begin
            snd_phase <= snd_phase_nxt;
            sonido    <= sonido_nxt;
        end
    end
`else
    assign sonido = 1'b0;
`endif

endmodule

// File: tb/tb_semaforo_peatonal.sv
// tb/tb_semaforo_peatonal.sv - randomized bench for semaforo_peatonal against a phase/timing model
module tb_semaforo_peatonal;

    localparam int T_DEBOUNCE = 4;
    localparam int T_WALK     = 10;
    localparam int T_CLEAR    = 6;
    localparam int T_FLASH    = 2;

    localparam int P_IDLE = 0, P_ESPERA = 1, P_CRUCE = 2, P_DESPEJE = 3, P_FIN = 4, P_FALLA = 5;

    logic clk = 1'b0;
    logic rst, pulsador, rojo_in, amarillo_in, verde_in;
    logic solicitud, espera, peaton_verde, peaton_rojo, falla, sonido;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int m_phase;
    int m_t;
    bit m_pend, m_s1, m_s2, m_deb;
    bit m_hist[T_DEBOUNCE];

    always #5 clk = ~clk;

    semaforo_peatonal #(
        .T_DEBOUNCE(T_DEBOUNCE),
        .T_WALK    (T_WALK),
        .T_CLEAR   (T_CLEAR),
        .T_FLASH   (T_FLASH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pulsador    (pulsador),
        .rojo_in     (rojo_in),
        .amarillo_in (amarillo_in),
        .verde_in    (verde_in),
        .solicitud   (solicitud),
        .espera      (espera),
        .peaton_verde(peaton_verde),
        .peaton_rojo (peaton_rojo),
        .falla       (falla),
        .sonido      (sonido)
    );

    task automatic check(input string tag, input logic got, input logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b want %b", tag, cyc, got, want);
        end
    endtask

    // One clock edge of the reference: press = window of last T_DEBOUNCE synced samples all high
    task automatic model_step();
        bit all1, all0, press;
        int nxt;
        if (rst) begin
            m_phase = P_IDLE;
            m_t     = 0;
            m_pend  = 0;
            m_s1    = 0;
            m_s2    = 0;
            m_deb   = 0;
            for (int i = 0; i < T_DEBOUNCE; i++) m_hist[i] = 0;
            return;
        end
        for (int i = T_DEBOUNCE - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = m_s2;
        m_s2 = m_s1;
        m_s1 = pulsador;
        all1 = 1;
        all0 = 1;
        for (int i = 0; i < T_DEBOUNCE; i++) begin
            if (m_hist[i]) all0 = 0;
            else           all1 = 0;
        end
        press = 0;
        if (!m_deb && all1) begin
            m_deb = 1;
            press = 1;
        end else if (m_deb && all0) begin
            m_deb = 0;
        end
        nxt = m_phase;
        case (m_phase)
            P_IDLE:    if (press || m_pend) begin nxt = P_ESPERA; m_pend = 0; end
            P_ESPERA:  if (rojo_in) nxt = P_CRUCE;
            P_CRUCE: begin
                if (press) m_pend = 1;
                if (!rojo_in) nxt = P_IDLE;
                else if (m_t + 1 == T_WALK) nxt = P_DESPEJE;
            end
            P_DESPEJE: begin
                if (press) m_pend = 1;
                if (!rojo_in) nxt = P_IDLE;
                else if (m_t + 1 == T_CLEAR) nxt = P_FIN;
            end
            P_FIN: begin
                if (press) m_pend = 1;
                if (!rojo_in) nxt = P_IDLE;
            end
            default: nxt = m_phase;
        endcase
        if (int'(rojo_in) + int'(amarillo_in) + int'(verde_in) != 1) begin
            nxt    = P_FALLA;
            m_pend = 0;
        end
        m_t     = (nxt == m_phase) ? m_t + 1 : 0;
        m_phase = nxt;
    endtask

    task automatic tick();
        bit exp_verde, exp_walk, exp_snd;
        @(posedge clk);
        model_step();
        #1;
        exp_walk  = (m_phase == P_CRUCE) || (m_phase == P_DESPEJE);
        exp_verde = (m_phase == P_CRUCE) || (m_phase == P_DESPEJE && ((m_t / T_FLASH) % 2 == 0));
        exp_snd   = 0;
`ifdef SEMAFORO_PEATONAL_SONIDO_EN
        if (m_phase == P_CRUCE)   exp_snd = ((m_t / T_FLASH) % 2 == 0);
        if (m_phase == P_DESPEJE) exp_snd = (m_t % 2 == 0);
`endif
        check("solicitud",    solicitud,    m_phase == P_ESPERA);
        check("espera",       espera,       m_phase == P_ESPERA);
        check("peaton_verde", peaton_verde, exp_verde);
        check("peaton_rojo",  peaton_rojo,  !exp_walk);
        check("falla",        falla,        m_phase == P_FALLA);
        check("sonido",       sonido,       exp_snd);
        check("lamps_excl",   peaton_verde & peaton_rojo, 1'b0);
        cyc++;
    endtask

    task automatic set_lamps(input int veh);
        rojo_in     = (veh == 2);
        amarillo_in = (veh == 1);
        verde_in    = (veh == 0);
    endtask

    initial begin
        int veh, veh_left, btn_left, fault_wait, rst_left;
        logic [2:0] bad;

        rst      = 1;
        pulsador = 0;
        set_lamps(0);
        repeat (3) tick();
        rst = 0;

        // bounce then stable press, followed by one full crossing
        pulsador = 1; repeat (3) tick();
        pulsador = 0; tick();
        pulsador = 1; repeat (10) tick();
        pulsador = 0; repeat (4) tick();
        set_lamps(1); repeat (2) tick();
        set_lamps(2); repeat (24) tick();
        set_lamps(0); repeat (4) tick();

        veh        = 0;
        veh_left   = 5;
        btn_left   = 0;
        fault_wait = 0;
        rst_left   = 0;
        for (int n = 0; n < 6000; n++) begin
            if (veh_left == 0) begin
                veh = (veh + 1) % 3;
                veh_left = (veh == 0) ? $urandom_range(3, 25) :
                           (veh == 1) ? $urandom_range(1, 4) : $urandom_range(4, 40);
            end else begin
                veh_left--;
            end
            set_lamps(veh);

            if (btn_left > 0) begin
                pulsador = 1;
                btn_left--;
            end else begin
                pulsador = 0;
                if ($urandom_range(0, 29) == 0) btn_left = $urandom_range(1, 14);
            end

            if (fault_wait > 0) begin
                fault_wait--;
                if (fault_wait == 0) rst_left = 2;
            end else if (rst_left == 0 && $urandom_range(0, 399) == 0) begin
                do bad = 3'($urandom_range(0, 7));
                while (bad == 3'b100 || bad == 3'b010 || bad == 3'b001);
                {rojo_in, amarillo_in, verde_in} = bad;
                fault_wait = $urandom_range(3, 15);
            end else if (rst_left == 0 && $urandom_range(0, 699) == 0) begin
                rst_left = $urandom_range(1, 3);
            end

            if (rst_left > 0) begin
                rst = 1;
                rst_left--;
            end else begin
                rst = 0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
